// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm bell controller: the FSM state encoding,
// time constants and the counter widths.
//
// Optional feature macro: HOURLY_CHIME_EN adds the CHIME state. When it is
// undefined, the state is not part of the encoding.
package alarm_pkg;

  localparam int SEC_PER_MIN = 60;
  // The largest load is 59 min * 60 s = 3540, so 12 bits are enough.
  localparam int SEC_CNT_W   = 12;
  localparam int BEEP_CNT_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
`ifdef HOURLY_CHIME_EN
    , ST_CHIME  = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/beep_gen.sv
// Beep generator for the alarm bell controller. A phase counter toggles a
// square wave every BEEP_HALF clocks. The wave starts high on every (re)start.
// The registered bell_out is the wave gated by the audible enable.
//
// Ports:
//   clk_50M   in  system clock
//   rst_n     in  asynchronous active-low reset
//   start     in  restart the phase counter with the phase high
//   en        in  FSM is in an audible state (RING or CHIME)
//   bell_out  out gated beep drive (registered)
module beep_gen
  import alarm_pkg::*;
#(
  parameter int BEEP_HALF = 12_500_000
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic start,
  input  logic en,
  output logic bell_out
);

  localparam logic [BEEP_CNT_W-1:0] HALF_LAST = BEEP_CNT_W'(BEEP_HALF - 1);

  logic [BEEP_CNT_W-1:0] beep_cnt;
  logic                  phase;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      beep_cnt <= '0;
      phase    <= 1'b0;
      bell_out <= 1'b0;
    end else begin
      if (start) begin
        beep_cnt <= '0;
        phase    <= 1'b1;
      end else if (en) begin
        if (beep_cnt == HALF_LAST) begin
          beep_cnt <= '0;
          phase    <= ~phase;
        end else begin
          beep_cnt <= beep_cnt + 1'b1;
        end
      end else begin
        beep_cnt <= '0;
      end
      bell_out <= phase & en;
    end
  end

endmodule

// File: rtl/alarm_bell_ctrl.sv
// Alarm bell controller. It has a bank of NUM_ALARMS alarm channels (hour,
// minute, arm) and an FSM that rings, snoozes and stops. A beep generator
// drives the bell output.
//
// Optional feature macro: HOURLY_CHIME_EN. With it defined, the controller
// chimes for RING_SEC seconds at every full hour when no alarm matches.
//
// Ports:
//   clk_50M                         in   system clock
//   rst_n                           in   asynchronous active-low reset
//   sec_tick                        in   one-cycle pulse per second
//   hour_time/minute_time/second_time in binary current time
//   wr_en/wr_idx/wr_hour/wr_minute/wr_arm in  alarm channel write port
//   snooze, stop                    in   one-cycle user pulses
//   bell_out                        out  gated beep drive
//   ringing                         out  FSM is in RING
//   active_idx                      out  channel that is ringing or snoozed
//   snooze_cnt                      out  snoozes used by the current event
module alarm_bell_ctrl
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int RING_SEC   = 6,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int BEEP_HALF  = 12_500_000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic [7:0] hour_time,
  input  logic [7:0] minute_time,
  input  logic [7:0] second_time,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  logic [7:0] wr_hour,
  input  logic [7:0] wr_minute,
  input  logic       wr_arm,
  input  logic       snooze,
  input  logic       stop,
  output logic       bell_out,
  output logic       ringing,
  output logic [2:0] active_idx,
  output logic [1:0] snooze_cnt
);

  localparam logic [SEC_CNT_W-1:0] RING_LOAD   = SEC_CNT_W'(RING_SEC);
  localparam logic [SEC_CNT_W-1:0] SNOOZE_LOAD = SEC_CNT_W'(SNOOZE_MIN * SEC_PER_MIN);

  // Channel bank
  logic [7:0]            ch_hour   [NUM_ALARMS];
  logic [7:0]            ch_minute [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] ch_arm;

  // A write only lands when wr_idx equals an existing channel, so indices at
  // or above NUM_ALARMS are dropped.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        ch_hour[i]   <= '0;
        ch_minute[i] <= '0;
      end
      ch_arm <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (wr_idx == 3'(i)) begin
          ch_hour[i]   <= wr_hour;
          ch_minute[i] <= wr_minute;
          ch_arm[i]    <= wr_arm;
        end
      end
    end
  end

  // Match detection: the loop runs downwards so the lowest index wins.
  logic       hit;
  logic [2:0] hit_idx;
  logic       alarm_match;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (ch_arm[i] && ch_hour[i] == hour_time && ch_minute[i] == minute_time) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  assign alarm_match = sec_tick && (second_time == 8'd0) && hit;

`ifdef HOURLY_CHIME_EN
  logic top_of_hour;
  assign top_of_hour = sec_tick && (minute_time == 8'd0) && (second_time == 8'd0);
`endif

  // Disarming the channel that owns the current event cancels the event.
  logic disarm_kill;
  assign disarm_kill = wr_en && !wr_arm && (wr_idx == active_idx);

  // FSM
  state_t               state, state_nxt;
  logic [SEC_CNT_W-1:0] sec_cnt, sec_cnt_nxt;
  logic [2:0]           idx_nxt;
  logic [1:0]           snz_nxt;
  logic                 expire;
  logic                 can_snooze;

  // A count of 1 on a tick means this tick is the final second.
  assign expire     = (sec_cnt <= SEC_CNT_W'(1));
  assign can_snooze = (32'(snooze_cnt) < MAX_SNOOZE);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sec_cnt    <= '0;
      active_idx <= '0;
      snooze_cnt <= '0;
    end else begin
      state      <= state_nxt;
      sec_cnt    <= sec_cnt_nxt;
      active_idx <= idx_nxt;
      snooze_cnt <= snz_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sec_cnt_nxt = sec_cnt;
    idx_nxt     = active_idx;
    snz_nxt     = snooze_cnt;
    case (state)
      ST_IDLE: begin
        if (alarm_match) begin
          state_nxt   = ST_RING;
          idx_nxt     = hit_idx;
          snz_nxt     = '0;
          sec_cnt_nxt = RING_LOAD;
        end
`ifdef HOURLY_CHIME_EN
        else if (top_of_hour) begin
          state_nxt   = ST_CHIME;
          sec_cnt_nxt = RING_LOAD;
        end
`endif
      end
      ST_RING: begin
        if (stop || disarm_kill) begin
          state_nxt   = ST_IDLE;
          sec_cnt_nxt = '0;
        end else if (snooze) begin
          if (can_snooze) begin
            state_nxt   = ST_SNOOZE;
            snz_nxt     = snooze_cnt + 2'd1;
            sec_cnt_nxt = SNOOZE_LOAD;
          end else begin
            state_nxt   = ST_IDLE;
            sec_cnt_nxt = '0;
          end
        end else if (sec_tick) begin
          if (expire) begin
            state_nxt   = ST_IDLE;
            sec_cnt_nxt = '0;
          end else begin
            sec_cnt_nxt = sec_cnt - 1'b1;
          end
        end
      end
      ST_SNOOZE: begin
        if (stop || disarm_kill) begin
          state_nxt   = ST_IDLE;
          sec_cnt_nxt = '0;
        end else if (sec_tick) begin
          if (expire) begin
            state_nxt   = ST_RING;
            sec_cnt_nxt = RING_LOAD;
          end else begin
            sec_cnt_nxt = sec_cnt - 1'b1;
          end
        end
      end
`ifdef HOURLY_CHIME_EN
      ST_CHIME: begin
        // A real alarm preempts the chime. Snooze has no meaning here.
        if (alarm_match) begin
          state_nxt   = ST_RING;
          idx_nxt     = hit_idx;
          snz_nxt     = '0;
          sec_cnt_nxt = RING_LOAD;
        end else if (stop) begin
          state_nxt   = ST_IDLE;
          sec_cnt_nxt = '0;
        end else if (sec_tick) begin
          if (expire) begin
            state_nxt   = ST_IDLE;
            sec_cnt_nxt = '0;
          end else begin
            sec_cnt_nxt = sec_cnt - 1'b1;
          end
        end
      end
`endif
      default: begin
        state_nxt   = ST_IDLE;
        sec_cnt_nxt = '0;
      end
    endcase
  end

  assign ringing = (state == ST_RING);

  // Beep control: the wave restarts whenever the FSM moves into an audible
  // state, including CHIME -> RING.
  logic audible, audible_nxt, beep_start;

`ifdef HOURLY_CHIME_EN
  assign audible     = (state == ST_RING) || (state == ST_CHIME);
  assign audible_nxt = (state_nxt == ST_RING) || (state_nxt == ST_CHIME);
`else
  assign audible     = (state == ST_RING);
  assign audible_nxt = (state_nxt == ST_RING);
`endif

  assign beep_start = audible_nxt && (state_nxt != state);

  beep_gen #(
    .BEEP_HALF(BEEP_HALF)
  ) u_beep_gen (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .start   (beep_start),
    .en      (audible),
    .bell_out(bell_out)
  );

endmodule
